// File: rtl/fifo_sync_pkg.sv
// Shared types, width helpers and flag reset values for the multi-width sync FIFO.
package fifo_sync_pkg;

  // Same bit order as the TDP18K FIFO fflags bundle, FULL in the MSB.
  typedef struct packed {
    logic full;
    logic fmo;
    logic fwm;
    logic overrun;
    logic empty;
    logic epo;
    logic ewm;
    logic underrun;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RST = '{
    full:     1'b0,
    fmo:      1'b0,
    fwm:      1'b0,
    overrun:  1'b0,
    empty:    1'b1,
    epo:      1'b0,
    ewm:      1'b1,
    underrun: 1'b0
  };

  function automatic int min_f(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync_flags.sv
// Registered status flags for fifo_sync_mw, derived from the post-edge atom fill level.
module fifo_sync_flags
  import fifo_sync_pkg::*;
#(
  parameter int LW       = 12,
  parameter int WM_W     = 11,
  parameter int DEPTH    = 2048,
  parameter int WR_ATOMS = 2,
  parameter int RD_ATOMS = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              flush,
  input  logic              ovr_set,
  input  logic              und_set,
  input  logic [LW-1:0]     level_nxt,
  input  logic [WM_W-1:0]   upaf,
  input  logic [WM_W-1:0]   upae,
  output fifo_flags_t       flags
);

  localparam int WR_SH     = clog2_f(WR_ATOMS);
  localparam int RD_SH     = clog2_f(RD_ATOMS);
  localparam int CAP_WORDS = DEPTH / WR_ATOMS;

  logic [LW-1:0] free_atoms;
  logic [31:0]   free_words;
  logic [31:0]   rd_words;
  fifo_flags_t   flags_nxt;
  fifo_flags_t   flags_q;
  logic          init_q;

  always_comb begin
    free_atoms         = LW'(DEPTH) - level_nxt;
    free_words         = 32'(free_atoms >> WR_SH);
    rd_words           = 32'(level_nxt >> RD_SH);
    flags_nxt          = FLAGS_RST;
    flags_nxt.full     = (free_words == 32'd0);
    flags_nxt.fmo      = (free_words == 32'd1);
    flags_nxt.fwm      = (free_words <= 32'(upaf));
    flags_nxt.overrun  = ~flush & (flags_q.overrun | ovr_set);
    flags_nxt.empty    = (rd_words == 32'd0);
    flags_nxt.epo      = (rd_words == 32'd1);
    flags_nxt.ewm      = (rd_words <= 32'(upae));
    flags_nxt.underrun = ~flush & (flags_q.underrun | und_set);
  end

  // init_q covers the window before the first edge, where FWM has no registered value yet.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      flags_q <= FLAGS_RST;
      init_q  <= 1'b1;
    end else begin
      flags_q <= flags_nxt;
      init_q  <= 1'b0;
    end
  end

  always_comb begin
    flags = flags_q;
    if (init_q) flags.fwm = (32'(upaf) >= 32'(CAP_WORDS));
  end

endmodule

// File: rtl/fifo_sync_mw.sv
// Single-clock FIFO with independent write/read widths, watermarks and sticky errors.
// Define FIFO_SYNC_MW_FWFT_EN for first-word fall-through reads (zero read latency).
module fifo_sync_mw
  import fifo_sync_pkg::*;
#(
  parameter int WR_WIDTH    = 18,
  parameter int RD_WIDTH    = 9,
  parameter int ATOM_ADDR_W = 11,
  parameter int WM_W        = 11
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   FLUSH,
  input  logic                   WEN,
  input  logic [WR_WIDTH-1:0]    WDATA,
  input  logic                   REN,
  output logic [RD_WIDTH-1:0]    RDATA,
  input  logic [WM_W-1:0]        UPAF,
  input  logic [WM_W-1:0]        UPAE,
  output logic                   FULL,
  output logic                   FMO,
  output logic                   FWM,
  output logic                   OVERRUN,
  output logic                   EMPTY,
  output logic                   EPO,
  output logic                   EWM,
  output logic                   UNDERRUN,
  output logic [ATOM_ADDR_W:0]   LEVEL
);

  localparam int ATOM_W   = min_f(WR_WIDTH, RD_WIDTH);
  localparam int WR_ATOMS = WR_WIDTH / ATOM_W;
  localparam int RD_ATOMS = RD_WIDTH / ATOM_W;
  localparam int DEPTH    = 1 << ATOM_ADDR_W;
  localparam int LW       = ATOM_ADDR_W + 1;

  logic [ATOM_W-1:0]   mem [DEPTH];
  logic [LW-1:0]       wptr_q;
  logic [LW-1:0]       rptr_q;
  logic [LW-1:0]       level_q;
  logic [LW-1:0]       level_nxt;
  logic [RD_WIDTH-1:0] rd_word;
  logic                wr_acc;
  logic                rd_acc;
  fifo_flags_t         flags;

  // Accepts use the registered flags; FLUSH overrides both sides.
  assign wr_acc = WEN & ~flags.full  & ~FLUSH;
  assign rd_acc = REN & ~flags.empty & ~FLUSH;

  always_comb begin
    level_nxt = level_q + (wr_acc ? LW'(WR_ATOMS) : '0) - (rd_acc ? LW'(RD_ATOMS) : '0);
    if (FLUSH) level_nxt = '0;
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < RD_ATOMS; k++)
      rd_word[k*ATOM_W +: ATOM_W] = mem[ATOM_ADDR_W'(rptr_q + LW'(k))];
  end

  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      for (int k = 0; k < WR_ATOMS; k++)
        mem[ATOM_ADDR_W'(wptr_q + LW'(k))] <= WDATA[k*ATOM_W +: ATOM_W];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      level_q <= level_nxt;
      if (FLUSH) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (wr_acc) wptr_q <= wptr_q + LW'(WR_ATOMS);
        if (rd_acc) rptr_q <= rptr_q + LW'(RD_ATOMS);
      end
    end
  end

`ifdef FIFO_SYNC_MW_FWFT_EN
  assign RDATA = rd_word;
`else
  logic [RD_WIDTH-1:0] rdata_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      rdata_q <= '0;
    else if (rd_acc) rdata_q <= rd_word;
  end

  assign RDATA = rdata_q;
`endif

  fifo_sync_flags #(
    .LW       (LW),
    .WM_W     (WM_W),
    .DEPTH    (DEPTH),
    .WR_ATOMS (WR_ATOMS),
    .RD_ATOMS (RD_ATOMS)
  ) u_flags (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .flush     (FLUSH),
    .ovr_set   (WEN & flags.full),
    .und_set   (REN & flags.empty),
    .level_nxt (level_nxt),
    .upaf      (UPAF),
    .upae      (UPAE),
    .flags     (flags)
  );

  assign FULL     = flags.full;
  assign FMO      = flags.fmo;
  assign FWM      = flags.fwm;
  assign OVERRUN  = flags.overrun;
  assign EMPTY    = flags.empty;
  assign EPO      = flags.epo;
  assign EWM      = flags.ewm;
  assign UNDERRUN = flags.underrun;
  assign LEVEL    = level_q;

endmodule

// File: tb/tb_fifo_sync_mw.sv
// Bench for fifo_sync_mw: vector table, directed corner sequences and a queue-based reference model.
module tb_fifo_sync_mw;

  logic        CLK;
  logic        RST_N;
  logic        FLUSH;
  logic        WEN;
  logic [17:0] WDATA;
  logic        REN;
  logic [8:0]  RDATA;
  logic [10:0] UPAF;
  logic [10:0] UPAE;
  logic        FULL, FMO, FWM, OVERRUN, EMPTY, EPO, EWM, UNDERRUN;
  logic [11:0] LEVEL;

  logic        w_flush, w_wen, w_ren;
  logic [7:0]  w_wdata;
  logic [31:0] w_rdata;
  logic [10:0] w_upaf, w_upae;
  logic        w_full, w_fmo, w_fwm, w_ovr, w_empty, w_epo, w_ewm, w_und;
  logic [4:0]  w_level;

  fifo_sync_mw dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .WEN(WEN), .WDATA(WDATA),
    .REN(REN), .RDATA(RDATA), .UPAF(UPAF), .UPAE(UPAE),
    .FULL(FULL), .FMO(FMO), .FWM(FWM), .OVERRUN(OVERRUN),
    .EMPTY(EMPTY), .EPO(EPO), .EWM(EWM), .UNDERRUN(UNDERRUN), .LEVEL(LEVEL)
  );

  fifo_sync_mw #(.WR_WIDTH(8), .RD_WIDTH(32), .ATOM_ADDR_W(4), .WM_W(11)) dut_w (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(w_flush), .WEN(w_wen), .WDATA(w_wdata),
    .REN(w_ren), .RDATA(w_rdata), .UPAF(w_upaf), .UPAE(w_upae),
    .FULL(w_full), .FMO(w_fmo), .FWM(w_fwm), .OVERRUN(w_ovr),
    .EMPTY(w_empty), .EPO(w_epo), .EWM(w_ewm), .UNDERRUN(w_und), .LEVEL(w_level)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO of 9-bit atoms, capacity 2048 atoms = 1024 write words.
  int unsigned mq[$];
  logic        m_ovr, m_und, m_fwm, m_ewm;
  logic [8:0]  m_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic wen, input logic [17:0] wd, input logic ren, input logic fl);
    int sz, fw;
    logic full_b, empty_b;
    logic [19:0] exp_st;
    WEN = wen; WDATA = wd; REN = ren; FLUSH = fl;
    sz = mq.size();
    full_b  = ((2048 - sz) / 2) < 1;
    empty_b = sz < 1;
    @(posedge CLK);
    if (fl) begin
      mq.delete();
      m_ovr = 1'b0;
      m_und = 1'b0;
    end else begin
      if (ren && empty_b) m_und = 1'b1;
      if (wen && full_b)  m_ovr = 1'b1;
      if (ren && !empty_b) m_rdata = 9'(mq.pop_front());
      if (wen && !full_b) begin
        mq.push_back(int'(wd[8:0]));
        mq.push_back(int'(wd[17:9]));
      end
    end
    sz = mq.size();
    fw = (2048 - sz) / 2;
    m_fwm = fw <= int'(UPAF);
    m_ewm = sz <= int'(UPAE);
    #1;
    WEN = 1'b0; REN = 1'b0; FLUSH = 1'b0;
    exp_st = {12'(sz), fw < 1, fw == 1, m_fwm, m_ovr, sz < 1, sz == 1, m_ewm, m_und};
    check("model_state", 64'({LEVEL, FULL, FMO, FWM, OVERRUN, EMPTY, EPO, EWM, UNDERRUN}), 64'(exp_st));
`ifdef FIFO_SYNC_MW_FWFT_EN
    if (sz > 0) check("model_rdata_fwft", 64'(RDATA), 64'(mq[0]));
`else
    check("model_rdata", 64'(RDATA), 64'(m_rdata));
`endif
  endtask

  task automatic do_reset(input logic [10:0] upaf_v, input logic exp_fwm);
    UPAF = upaf_v;
    RST_N = 1'b0;
    #2;
    check("rst_level", 64'(LEVEL), 64'd0);
    check("rst_flags", 64'({FULL, FMO, FWM, OVERRUN, EMPTY, EPO, EWM, UNDERRUN}),
          64'({1'b0, 1'b0, exp_fwm, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}));
`ifndef FIFO_SYNC_MW_FWFT_EN
    check("rst_rdata", 64'(RDATA), 64'd0);
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    mq.delete();
    m_ovr = 1'b0; m_und = 1'b0; m_rdata = '0;
  endtask

  task automatic wstep(input logic wen, input logic [7:0] wd, input logic ren);
    w_wen = wen; w_wdata = wd; w_ren = ren;
    @(posedge CLK);
    #1;
    w_wen = 1'b0; w_ren = 1'b0;
  endtask

  typedef struct {
    logic        wen;
    logic        ren;
    logic        fl;
    logic [17:0] wd;
    logic [11:0] lvl;
    logic        emp, epo, ewm, und;
    logic [8:0]  rd;
    logic        fw_chk;
    logic [8:0]  fw_rd;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [7:0] wbytes [4];
    logic       wemp   [4];

    vt[0] = '{1'b1, 1'b0, 1'b0, 18'h31234, 12'd2, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 9'h034};
    vt[1] = '{1'b0, 1'b1, 1'b0, 18'h00000, 12'd1, 1'b0, 1'b1, 1'b1, 1'b0, 9'h034, 1'b1, 9'h189};
    vt[2] = '{1'b0, 1'b1, 1'b0, 18'h00000, 12'd0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h189, 1'b0, 9'h000};
    vt[3] = '{1'b0, 1'b1, 1'b0, 18'h00000, 12'd0, 1'b1, 1'b0, 1'b1, 1'b1, 9'h189, 1'b0, 9'h000};
    vt[4] = '{1'b1, 1'b1, 1'b0, 18'h2AAAA, 12'd2, 1'b0, 1'b0, 1'b0, 1'b1, 9'h189, 1'b1, 9'h0AA};
    vt[5] = '{1'b1, 1'b0, 1'b1, 18'h3FFFF, 12'd0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h189, 1'b0, 9'h000};

    FLUSH = 1'b0; WEN = 1'b0; REN = 1'b0; WDATA = '0; UPAE = 11'd1;
    w_flush = 1'b0; w_wen = 1'b0; w_ren = 1'b0; w_wdata = '0; w_upaf = '0; w_upae = '0;
    RST_N = 1'b1;
    #1;
    do_reset(11'd1100, 1'b1);
    UPAF = 11'd4;

    for (int i = 0; i < 6; i++) begin
      step(vt[i].wen, vt[i].wd, vt[i].ren, vt[i].fl);
      check($sformatf("vec%0d_level", i), 64'(LEVEL), 64'(vt[i].lvl));
      check($sformatf("vec%0d_flags", i), 64'({EMPTY, EPO, EWM, UNDERRUN}),
            64'({vt[i].emp, vt[i].epo, vt[i].ewm, vt[i].und}));
`ifdef FIFO_SYNC_MW_FWFT_EN
      if (vt[i].fw_chk) check($sformatf("vec%0d_rdata", i), 64'(RDATA), 64'(vt[i].fw_rd));
`else
      check($sformatf("vec%0d_rdata", i), 64'(RDATA), 64'(vt[i].rd));
`endif
    end

    // 8-bit in, 32-bit out: one read word needs four writes.
    wbytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    wemp   = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      wstep(1'b1, wbytes[i], 1'b0);
      check($sformatf("wide_empty%0d", i), 64'(w_empty), 64'(wemp[i]));
    end
    check("wide_level4", 64'(w_level), 64'd4);
`ifdef FIFO_SYNC_MW_FWFT_EN
    check("wide_fwft_rdata", 64'(w_rdata), 64'h44332211);
`endif
    wstep(1'b0, 8'h00, 1'b1);
`ifndef FIFO_SYNC_MW_FWFT_EN
    check("wide_rdata", 64'(w_rdata), 64'h44332211);
`endif
    check("wide_empty_after", 64'({w_empty, w_level}), 64'({1'b1, 5'd0}));

    // Fill to full with UPAF=2, then overrun.
    UPAF = 11'd2;
    for (int i = 1; i <= 1024; i++) begin
      step(1'b1, 18'($urandom), 1'b0, 1'b0);
      if (i == 1021) check("fill_fwm_1021", 64'(FWM), 64'd0);
      if (i == 1022) check("fill_fwm_1022", 64'({FWM, FMO}), 64'({1'b1, 1'b0}));
      if (i == 1023) check("fill_fmo_1023", 64'({FMO, FULL}), 64'({1'b1, 1'b0}));
      if (i == 1024) check("fill_full_1024", 64'({FULL, FMO, LEVEL}), 64'({1'b1, 1'b0, 12'd2048}));
    end
    step(1'b1, 18'h3FFFF, 1'b0, 1'b0);
    check("ovr_set", 64'({OVERRUN, LEVEL}), 64'({1'b1, 12'd2048}));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 18'h0, 1'b0, 1'b0);
      check("ovr_sticky", 64'(OVERRUN), 64'd1);
    end
    step(1'b1, 18'h12345, 1'b1, 1'b0);
    check("full_wr_rd", 64'({FULL, LEVEL}), 64'({1'b1, 12'd2047}));
    for (int i = 0; i < 2047; i++) step(1'b0, 18'h0, 1'b1, 1'b0);
    check("drained", 64'({EMPTY, LEVEL}), 64'({1'b1, 12'd0}));

    // Underrun, write accepted alongside an empty read, then flush half full.
    step(1'b0, 18'h0, 1'b1, 1'b0);
    check("und_set", 64'({UNDERRUN, LEVEL}), 64'({1'b1, 12'd0}));
    step(1'b1, 18'h0ABCD, 1'b1, 1'b0);
    check("und_wr_ok", 64'({UNDERRUN, LEVEL}), 64'({1'b1, 12'd2}));
    for (int i = 0; i < 511; i++) step(1'b1, 18'($urandom), 1'b0, 1'b0);
    check("half_full", 64'(LEVEL), 64'd1024);
    step(1'b1, 18'h15555, 1'b0, 1'b1);
    check("flush", 64'({LEVEL, EMPTY, OVERRUN, UNDERRUN}), 64'({12'd0, 1'b1, 1'b0, 1'b0}));

    // Almost-empty watermark on the way down.
    UPAE = 11'd3;
    UPAF = 11'd4;
    for (int i = 0; i < 4; i++) step(1'b1, 18'($urandom), 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 18'h0, 1'b1, 1'b0);
      if (i == 4) check("ewm_lvl4", 64'({EWM, LEVEL}), 64'({1'b0, 12'd4}));
      if (i == 5) check("ewm_lvl3", 64'({EWM, LEVEL}), 64'({1'b1, 12'd3}));
    end

    // Randomized traffic phases against the model.
    for (int c = 0; c < 4000; c++) begin
      int wp, rp;
      wp = (c < 1700) ? 85 : (c < 2400) ? 50 : 12;
      rp = (c < 1700) ? 15 : (c < 2400) ? 50 : 88;
      if ($urandom_range(0, 49) == 0) begin
        UPAF = 11'($urandom_range(0, 1100));
        UPAE = 11'($urandom_range(0, 2047));
      end
      step($urandom_range(0, 99) < wp, 18'($urandom), $urandom_range(0, 99) < rp,
           $urandom_range(0, 299) == 0);
    end

    // Reset in the middle of a burst discards everything.
    UPAE = 11'd1;
    step(1'b0, 18'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 18'($urandom), 1'b0, 1'b0);
    do_reset(11'd4, 1'b0);
    step(1'b0, 18'h0, 1'b0, 1'b0);
    check("post_rst_level", 64'(LEVEL), 64'd0);
    step(1'b1, 18'h31234, 1'b0, 1'b0);
    step(1'b0, 18'h0, 1'b1, 1'b0);
`ifndef FIFO_SYNC_MW_FWFT_EN
    check("post_rst_rdata", 64'(RDATA), 64'h034);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
